// File: rtl/cdb_arbiter.sv
// Common Data Bus transmit side: per-source completion FIFOs feeding a registered,
// round-robin arbitrated single broadcast per cycle.
module cdb_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 2,
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [SRC_W-1:0]          cdb_src
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [SRC_W:0]   NUM_SRC_X = (SRC_W + 1)'(NUM_SRC);
   localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);

   logic [NUM_SRC-1:0] non_empty;
   logic [TAG_W-1:0]   head_tag  [NUM_SRC];
   logic [DATA_W-1:0]  head_data [NUM_SRC];
   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W:0]     cand;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
      logic [TAG_W-1:0]  mem_tag  [DEPTH];
      logic [DATA_W-1:0] mem_data [DEPTH];
      logic [PTR_W-1:0]  wptr;
      logic [PTR_W-1:0]  rptr;
      logic [CNT_W-1:0]  count;
      logic              push;
      logic              pop;

      // ready depends only on the registered count, never on a same-cycle pop
      assign src_ready[i] = (count != CNT_FULL);
      assign non_empty[i] = (count != '0);
      assign push         = src_valid[i] && src_ready[i];
      assign pop          = grant_valid && (grant_idx == SRC_W'(i));
      assign head_tag[i]  = mem_tag[rptr];
      assign head_data[i] = mem_data[rptr];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push) begin
            mem_tag[wptr]  <= src_tag[i*TAG_W +: TAG_W];
            mem_data[wptr] <= src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Search upward from rr_ptr with wrap; first non-empty FIFO wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
         if (cand >= NUM_SRC_X) cand = cand - NUM_SRC_X;
         if (!grant_valid && non_empty[cand[SRC_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[SRC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
         rr_ptr    <= '0;
      end else begin
         cdb_valid <= grant_valid;
         if (grant_valid) begin
            cdb_tag  <= head_tag[grant_idx];
            cdb_data <= head_data[grant_idx];
            cdb_src  <= grant_idx;
            rr_ptr   <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_SRC=2, DEPTH=2.
module tb_cdb_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  src_valid;
   logic [11:0] src_tag;
   logic [63:0] src_data;
   logic [1:0]  src_ready;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [0:0]  cdb_src;

   int checks = 0;
   int errors = 0;

   cdb_arbiter #(.NUM_SRC(2), .TAG_W(6), .DATA_W(32), .DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .src_ready (src_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      src_valid = 2'b00;
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src_valid = 2'($urandom);
         src_tag   = 12'($urandom);
         src_data  = {$urandom, $urandom};
         step();
      end
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", cdb_valid); end
      checks++; if (cdb_tag !== 6'd0) begin errors++; $display("FAIL reset_tag got %0h exp 0", cdb_tag); end
      checks++; if (cdb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", cdb_data); end
      checks++; if (cdb_src !== 1'b0) begin errors++; $display("FAIL reset_src got %0h exp 0", cdb_src); end
      checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %0b exp 11", src_ready); end
      src_valid = 2'b00;
      reset = 1'b1;
      step(); step(); step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL release_idle got %0h exp 0", cdb_valid); end
      checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL release_ready got %0b exp 11", src_ready); end
   endtask

   task automatic test_single();
      src_valid = 2'b01;
      src_tag   = {6'd0, 6'd5};
      src_data  = {32'h0, 32'hDEADBEEF};
      step();
      src_valid = 2'b00;
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0h exp 0", cdb_valid); end
      step();
      checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", cdb_valid); end
      checks++; if (cdb_tag !== 6'd5) begin errors++; $display("FAIL single_tag got %0d exp 5", cdb_tag); end
      checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %0h exp deadbeef", cdb_data); end
      checks++; if (cdb_src !== 1'b0) begin errors++; $display("FAIL single_src got %0d exp 0", cdb_src); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %0h exp 0", cdb_valid); end
      checks++; if (cdb_tag !== 6'd5) begin errors++; $display("FAIL single_tag_hold got %0d exp 5", cdb_tag); end
      checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_hold got %0h exp deadbeef", cdb_data); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      src_valid = 2'b11;
      src_tag   = {6'd2, 6'd1};
      src_data  = {32'h2222, 32'h1111};
      step();
      src_valid = 2'b00;
      step();
      checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd1 || cdb_src !== 1'b0) begin errors++; $display("FAIL simul_first got v%0d tag %0d src %0d exp v1 tag 1 src 0", cdb_valid, cdb_tag, cdb_src); end
      checks++; if (cdb_data !== 32'h1111) begin errors++; $display("FAIL simul_first_data got %0h exp 1111", cdb_data); end
      step();
      checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd2 || cdb_src !== 1'b1) begin errors++; $display("FAIL simul_second got v%0d tag %0d src %0d exp v1 tag 2 src 1", cdb_valid, cdb_tag, cdb_src); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL simul_idle got %0h exp 0", cdb_valid); end
      // rr_ptr is back at 0: src0 first again
      src_valid = 2'b11;
      src_tag   = {6'd4, 6'd3};
      step();
      src_valid = 2'b00;
      step();
      checks++; if (cdb_tag !== 6'd3 || cdb_src !== 1'b0) begin errors++; $display("FAIL repeat_first got tag %0d src %0d exp tag 3 src 0", cdb_tag, cdb_src); end
      step();
      checks++; if (cdb_tag !== 6'd4 || cdb_src !== 1'b1) begin errors++; $display("FAIL repeat_second got tag %0d src %0d exp tag 4 src 1", cdb_tag, cdb_src); end
      step();
      src_valid = 2'b01;
      src_tag   = {6'd0, 6'd7};
      step();
      src_valid = 2'b00;
      step();
      checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd7) begin errors++; $display("FAIL lone_src0 got v%0d tag %0d exp v1 tag 7", cdb_valid, cdb_tag); end
      // rr_ptr is now 1: src1 must win the fresh pair
      src_valid = 2'b11;
      src_tag   = {6'd9, 6'd8};
      step();
      src_valid = 2'b00;
      step();
      checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd9 || cdb_src !== 1'b1) begin errors++; $display("FAIL rr1_first got v%0d tag %0d src %0d exp v1 tag 9 src 1", cdb_valid, cdb_tag, cdb_src); end
      step();
      checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd8 || cdb_src !== 1'b0) begin errors++; $display("FAIL rr1_second got v%0d tag %0d src %0d exp v1 tag 8 src 0", cdb_valid, cdb_tag, cdb_src); end
      step();
   endtask

   task automatic test_backpressure();
      int acc0 = 0;
      int acc1 = 0;
      int seen1 = 0;
      bit a0, a1;
      apply_reset();
      for (int cyc = 1; cyc <= 20; cyc++) begin
         src_valid[0] = (cyc <= 10);
         src_valid[1] = (acc1 < 3);
         src_tag  = {6'(10 + acc1), 6'(32 + acc0)};
         src_data = {32'(acc1), 32'(acc0)};
         a0 = src_valid[0] && src_ready[0];
         a1 = src_valid[1] && src_ready[1];
         step();
         if (a0) acc0++;
         if (a1) acc1++;
         if (cyc == 2) begin
            checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL bp_src1_full got %0b exp 01", src_ready); end
         end
         if (cyc == 3) begin
            checks++; if (src_ready !== 2'b10) begin errors++; $display("FAIL bp_after_pop got %0b exp 10", src_ready); end
         end
         if (cdb_valid && cdb_src == 1'b1) begin
            checks++; if (cdb_tag !== 6'(10 + seen1)) begin errors++; $display("FAIL bp_order got %0d exp %0d", cdb_tag, 10 + seen1); end
            seen1++;
         end
      end
      src_valid = 2'b00;
      checks++; if (seen1 !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", seen1); end
      checks++; if (acc1 !== 3) begin errors++; $display("FAIL bp_accepted got %0d exp 3", acc1); end
   endtask

   task automatic test_fairness();
      int acc0 = 0;
      int acc1 = 0;
      int b0 = 0;
      int b1 = 0;
      int nobs = 0;
      bit a0, a1;
      apply_reset();
      for (int cyc = 0; cyc < 30; cyc++) begin
         src_valid = 2'b11;
         src_tag   = {6'(32 + acc1), 6'(acc0)};
         a0 = src_ready[0];
         a1 = src_ready[1];
         step();
         if (a0) acc0++;
         if (a1) acc1++;
         if ((cdb_valid || nobs > 0) && nobs < 20) begin
            checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL fair_gap at %0d got %0d exp 1", nobs, cdb_valid); end
            checks++; if (cdb_src !== 1'(nobs % 2)) begin errors++; $display("FAIL fair_src at %0d got %0d exp %0d", nobs, cdb_src, nobs % 2); end
            if (cdb_src == 1'b0) begin
               checks++; if (cdb_tag !== 6'(b0)) begin errors++; $display("FAIL fair_tag0 got %0d exp %0d", cdb_tag, b0); end
               b0++;
            end else begin
               checks++; if (cdb_tag !== 6'(32 + b1)) begin errors++; $display("FAIL fair_tag1 got %0d exp %0d", cdb_tag, 32 + b1); end
               b1++;
            end
            nobs++;
         end
      end
      src_valid = 2'b00;
      checks++; if (b0 !== 10 || b1 !== 10) begin errors++; $display("FAIL fair_counts got %0d/%0d exp 10/10", b0, b1); end
      step(); step(); step(); step();
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      apply_reset();
      src_valid = 2'b11;
      src_tag   = {6'd60, 6'd50};
      step();
      src_tag   = {6'd61, 6'd51};
      step();
      src_valid = 2'b00;
      reset = 1'b0;
      #1;
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0h exp 0", cdb_valid); end
      checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL mid_ready got %0b exp 11", src_ready); end
      checks++; if (cdb_tag !== 6'd0) begin errors++; $display("FAIL mid_tag got %0d exp 0", cdb_tag); end
      step();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (cdb_valid) stale++;
      end
      checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d exp 0", stale); end
      checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL mid_ready_after got %0b exp 11", src_ready); end
   endtask

   initial begin
      reset     = 1'b0;
      src_valid = 2'b00;
      src_tag   = '0;
      src_data  = '0;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_fairness();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Transmit side of the Common Data Bus. Collects completion results (destination physical-register tag plus result data) from up to NUM_SRC execution units, buffers them in per-source FIFOs, and drives exactly one registered broadcast per cycle onto the CDB using round-robin arbitration. It sits between the ALU and other execution units and the reservation stations and register file that snoop `cdb_valid`/`cdb_tag`.

## Interface

Parameters:
- NUM_SRC, 2: number of producing execution units (2..4).
- TAG_W, 6: physical register tag width.
- DATA_W, 32: result data width.
- DEPTH, 2: entries per source FIFO (power of two, ≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while low.
- src_valid  input  NUM_SRC  per-source completion request.
- src_tag  input  NUM_SRC*TAG_W  packed tags; source i at bits [i*TAG_W +: TAG_W].
- src_data  input  NUM_SRC*DATA_W  packed results; source i at bits [i*DATA_W +: DATA_W].
- src_ready  output  NUM_SRC  per-source FIFO has space.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_data  output  DATA_W  registered broadcast data.
- cdb_src  output  clog2(NUM_SRC) (min 1)  index of the granted source for the current broadcast.

## Operation

- Per source i: circular FIFO of DEPTH entries {tag, data} with write pointer, read pointer, and count (0..DEPTH). Pointers wrap modulo DEPTH.
- `src_ready[i] = (count_i != DEPTH)`. This is a function of the registered count only; it does not depend on a same-cycle pop.
- Push: on an edge where `src_valid[i] && src_ready[i]`, write the entry at wptr_i and increment wptr_i.
- Arbitration is combinational over FIFO heads. Candidates are the sources with `count_i != 0`. Search starts at rr_ptr and proceeds upward with wrap; the first candidate wins.
- On a grant to source g:
  - Pop g's head (rptr_g++).
  - Register `cdb_valid=1`, `cdb_tag`/`cdb_data` = head of g, `cdb_src=g`.
  - Set `rr_ptr = (g+1) mod NUM_SRC`.
- No candidate: `cdb_valid=0`. `cdb_tag`, `cdb_data` and `cdb_src` hold their previous values. rr_ptr is unchanged.
- Push and pop on the same source in the same cycle: count unchanged, both pointers advance.
- The CDB never backpressures. Every granted entry is broadcast exactly once.
- There is no bypass: an entry must sit in the FIFO before it can be granted.
- Entries from one source are broadcast in arrival order. Ordering across sources is set only by arbitration.

## Timing

- Reset (reset=0):
  - All FIFO pointers and counts = 0; rr_ptr = 0.
  - `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `cdb_src=0`.
  - `src_ready` = all ones.
- Reset asserted mid-operation: all buffered entries are discarded immediately; no broadcast of them occurs after release.
- Latency:
  - An entry accepted at edge k is eligible at edge k+1.
  - If granted at edge k+1, `cdb_valid` is high during the cycle following edge k+1.
- Throughput: one broadcast per cycle sustained while any FIFO is non-empty.
- Full FIFO: `src_ready[i]=0` for the whole cycle. A `src_valid[i]` asserted in that cycle is ignored (not written) and the producer must hold it.
- With all NUM_SRC FIFOs continuously non-empty, each source is granted exactly once every NUM_SRC cycles.

## Test plan

- Reset values: hold reset=0 with random inputs → `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `src_ready=2'b11`. Release reset → still idle with no broadcast.
- Single source, NUM_SRC=2: push src0 tag=6'd5, data=32'hDEADBEEF at edge k → `cdb_valid=1`, `cdb_tag=5`, `cdb_data=DEADBEEF`, `cdb_src=0` after edge k+1. Then `cdb_valid=0` next cycle with tag/data held.
- Simultaneous push: src0 tag=1 and src1 tag=2 on the same edge after reset → broadcasts tag 1 then tag 2 on consecutive cycles. A repeat from rr_ptr=0 on the next round gives tag 1 first again; a fresh pair while rr_ptr=1 gives src1 first.
- Backpressure: hold src1 `src_valid=1` with tags 10,11,12 while src0 saturates. After 2 accepted entries, `src_ready[1]=0` until a pop. Tag 12 is accepted only after the pop, and tags broadcast in order 10,11,12 with no loss or duplicate.
- Sustained fairness: both sources always valid for 20 cycles → `cdb_src` alternates 0,1,0,1…. Exactly 10 broadcasts per source.
- Reset mid-operation: fill both FIFOs (4 entries), assert reset for one cycle → `cdb_valid=0`, no stale tags broadcast afterwards, `src_ready=2'b11`.
